mips_mcctrl: RTL and testbench



---
 rtl/mips_mcctrl.sv | 141 ++++++++++++++
 tb/tb_mips_mcctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mcctrl.sv
// Multicycle MIPS control unit: a Moore sequencer for a datapath with one shared ALU and one shared memory.
// Adds memory wait states, optional LHU/BLT, a sticky illegal-opcode trap and a retired-instruction counter.
module mips_mcctrl #(
    parameter int MEM_WAIT_EN = 1,
    parameter int EXT_EN      = 1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             memwrite,
    output logic             irwrite,
    output logic             pcwrite,
    output logic             branch,
    output logic             branch_lt,
    output logic             iord,
    output logic             regdst,
    output logic             regwrite,
    output logic             memtoreg,
    output logic             halfword,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic [1:0]       aluop,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_BEQ, S_BLTX, S_ADDIEX, S_ADDIWB, S_JUMP, S_TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BLT   = 6'b011101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam bit EXT = (EXT_EN != 0);

    state_t     state_reg, state_next;
    logic       is_sw_reg, is_sw_next;
    logic       is_lhu_reg, is_lhu_next;
    logic [CNT_W-1:0] instret_reg;
    logic       retire;
    logic       rdy;

    assign rdy = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

    always_comb begin
        state_next  = state_reg;
        is_sw_next  = is_sw_reg;
        is_lhu_next = is_lhu_reg;
        retire      = 1'b0;
        case (state_reg)
            S_FETCH:  if (rdy) state_next = S_DECODE;
            S_DECODE: begin
                // Memory op class is captured here so op may change once DECODE is over.
                is_sw_next  = (op == OP_SW);
                is_lhu_next = EXT && (op == OP_LHU);
                if (op == OP_RTYPE)
                    state_next = S_EXEC;
                else if (op == OP_LW || op == OP_SW || (EXT && op == OP_LHU))
                    state_next = S_MEMADR;
                else if (op == OP_BEQ)
                    state_next = S_BEQ;
                else if (EXT && op == OP_BLT)
                    state_next = S_BLTX;
                else if (op == OP_ADDI)
                    state_next = S_ADDIEX;
                else if (op == OP_J)
                    state_next = S_JUMP;
                else
                    state_next = S_TRAP;
            end
            S_MEMADR: state_next = is_sw_reg ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (rdy) state_next = S_MEMWB;
            S_MEMWR:  if (rdy) begin state_next = S_FETCH; retire = 1'b1; end
            S_EXEC:   state_next = S_ALUWB;
            S_ADDIEX: state_next = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BEQ, S_BLTX, S_ADDIWB, S_JUMP: begin
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            S_TRAP:   state_next = S_TRAP;
            default:  state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= S_FETCH;
            is_sw_reg   <= 1'b0;
            is_lhu_reg  <= 1'b0;
            instret_reg <= '0;
        end else begin
            state_reg   <= state_next;
            is_sw_reg   <= is_sw_next;
            is_lhu_reg  <= is_lhu_next;
            if (retire)
                instret_reg <= instret_reg + CNT_W'(1);
        end
    end

    // Controls follow the registered state; only FETCH's IR/PC loads wait on mem_ready.
    always_comb begin
        {mem_req, memwrite, irwrite, pcwrite, branch, branch_lt, iord, regdst,
         regwrite, memtoreg, halfword, alusrca, illegal} = '0;
        alusrcb = 2'b00;
        pcsrc   = 2'b00;
        aluop   = 2'b00;
        if (reset) begin
            case (state_reg)
                S_FETCH:  begin mem_req = 1'b1; irwrite = rdy; pcwrite = rdy; alusrcb = 2'b01; end
                S_DECODE: alusrcb = 2'b11;
                S_MEMADR: begin alusrca = 1'b1; alusrcb = 2'b10; end
                S_MEMRD:  begin mem_req = 1'b1; iord = 1'b1; end
                S_MEMWB:  begin regwrite = 1'b1; memtoreg = 1'b1; halfword = is_lhu_reg; end
                S_MEMWR:  begin mem_req = 1'b1; memwrite = 1'b1; iord = 1'b1; end
                S_EXEC:   begin alusrca = 1'b1; aluop = 2'b10; end
                S_ALUWB:  begin regwrite = 1'b1; regdst = 1'b1; end
                S_BEQ:    begin alusrca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; branch = 1'b1; end
                S_BLTX:   begin alusrca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; branch_lt = 1'b1; end
                S_ADDIEX: begin alusrca = 1'b1; alusrcb = 2'b10; end
                S_ADDIWB: regwrite = 1'b1;
                S_JUMP:   begin pcsrc = 2'b10; pcwrite = 1'b1; end
                S_TRAP:   illegal = 1'b1;
                default:  ;
            endcase
        end
    end

    assign instret = reset ? instret_reg : '0;

endmodule

// File: tb/tb_mips_mcctrl.sv
// Directed checks of mips_mcctrl: per-cycle control vectors against a hand-written state table,
// plus EXT_EN=0 trapping and CNT_W=4 counter wrap on side instances sharing the same stimulus.
module tb_mips_mcctrl;

    localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWBH = 5,
                   MEMWR = 6, EXEC = 7, ALUWB = 8, BEQ = 9, BLTX = 10, ADDIEX = 11,
                   ADDIWB = 12, JUMP = 13, TRAP = 14, ZERO = 15;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [5:0] op = 6'd0;
    logic mem_ready = 1'b1;

    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Default-parameter instance
    logic mem_req, memwrite, irwrite, pcwrite, branch, branch_lt, iord, regdst;
    logic regwrite, memtoreg, halfword, alusrca, illegal;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic [31:0] instret;
    logic [18:0] ctrl;
    assign ctrl = {mem_req, memwrite, irwrite, pcwrite, branch, branch_lt, iord, regdst,
                   regwrite, memtoreg, halfword, alusrca, alusrcb, pcsrc, aluop, illegal};

    mips_mcctrl dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .mem_req(mem_req), .memwrite(memwrite), .irwrite(irwrite), .pcwrite(pcwrite),
        .branch(branch), .branch_lt(branch_lt), .iord(iord), .regdst(regdst),
        .regwrite(regwrite), .memtoreg(memtoreg), .halfword(halfword), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .illegal(illegal), .instret(instret)
    );

    // EXT_EN=0 instance
    logic x_mem_req, x_memwrite, x_irwrite, x_pcwrite, x_branch, x_branch_lt, x_iord, x_regdst;
    logic x_regwrite, x_memtoreg, x_halfword, x_alusrca, x_illegal;
    logic [1:0] x_alusrcb, x_pcsrc, x_aluop;
    logic [31:0] x_instret;
    logic [18:0] x_ctrl;
    assign x_ctrl = {x_mem_req, x_memwrite, x_irwrite, x_pcwrite, x_branch, x_branch_lt, x_iord,
                     x_regdst, x_regwrite, x_memtoreg, x_halfword, x_alusrca, x_alusrcb, x_pcsrc,
                     x_aluop, x_illegal};

    mips_mcctrl #(.EXT_EN(0)) dut_x (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .mem_req(x_mem_req), .memwrite(x_memwrite), .irwrite(x_irwrite), .pcwrite(x_pcwrite),
        .branch(x_branch), .branch_lt(x_branch_lt), .iord(x_iord), .regdst(x_regdst),
        .regwrite(x_regwrite), .memtoreg(x_memtoreg), .halfword(x_halfword), .alusrca(x_alusrca),
        .alusrcb(x_alusrcb), .pcsrc(x_pcsrc), .aluop(x_aluop), .illegal(x_illegal),
        .instret(x_instret)
    );

    // CNT_W=4 instance
    logic c_mem_req, c_memwrite, c_irwrite, c_pcwrite, c_branch, c_branch_lt, c_iord, c_regdst;
    logic c_regwrite, c_memtoreg, c_halfword, c_alusrca, c_illegal;
    logic [1:0] c_alusrcb, c_pcsrc, c_aluop;
    logic [3:0] c_instret;

    mips_mcctrl #(.CNT_W(4)) dut_c (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .mem_req(c_mem_req), .memwrite(c_memwrite), .irwrite(c_irwrite), .pcwrite(c_pcwrite),
        .branch(c_branch), .branch_lt(c_branch_lt), .iord(c_iord), .regdst(c_regdst),
        .regwrite(c_regwrite), .memtoreg(c_memtoreg), .halfword(c_halfword), .alusrca(c_alusrca),
        .alusrcb(c_alusrcb), .pcsrc(c_pcsrc), .aluop(c_aluop), .illegal(c_illegal),
        .instret(c_instret)
    );

    // Expected control vector for a state, from the control table
    function automatic logic [18:0] exp_ctrl(input int st, input logic rdy);
        logic [18:0] v;
        v = '0;
        case (st)
            FETCH:  begin v[18] = 1'b1; v[16] = rdy; v[15] = rdy; v[6:5] = 2'b01; end
            DECODE: v[6:5] = 2'b11;
            MEMADR: begin v[7] = 1'b1; v[6:5] = 2'b10; end
            MEMRD:  begin v[18] = 1'b1; v[12] = 1'b1; end
            MEMWB:  begin v[10] = 1'b1; v[9] = 1'b1; end
            MEMWBH: begin v[10] = 1'b1; v[9] = 1'b1; v[8] = 1'b1; end
            MEMWR:  begin v[18] = 1'b1; v[17] = 1'b1; v[12] = 1'b1; end
            EXEC:   begin v[7] = 1'b1; v[2:1] = 2'b10; end
            ALUWB:  begin v[10] = 1'b1; v[11] = 1'b1; end
            BEQ:    begin v[7] = 1'b1; v[2:1] = 2'b01; v[4:3] = 2'b01; v[14] = 1'b1; end
            BLTX:   begin v[7] = 1'b1; v[2:1] = 2'b01; v[4:3] = 2'b01; v[13] = 1'b1; end
            ADDIEX: begin v[7] = 1'b1; v[6:5] = 2'b10; end
            ADDIWB: v[10] = 1'b1;
            JUMP:   begin v[4:3] = 2'b10; v[15] = 1'b1; end
            TRAP:   v[0] = 1'b1;
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic step(input int st, input logic rdy, input string tag);
        mem_ready = rdy;
        @(negedge clk);
        checks++;
        if (ctrl !== exp_ctrl(st, rdy)) begin
            fails++;
            $display("FAIL %s: ctrl=%b expected %b", tag, ctrl, exp_ctrl(st, rdy));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        mem_ready = 1'b1;
        op = 6'b000000;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        checks++;
        if (ctrl !== 19'd0 || instret !== 32'd0) begin
            fails++;
            $display("FAIL reset_state: ctrl=%b instret=%0d expected 0 and 0", ctrl, instret);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(FETCH, 1'b1, "reset_first_fetch");
        $display("test_reset done");
    endtask

    task automatic test_rtype();
        do_reset();
        op = 6'b000000;
        step(FETCH, 1'b1, "rtype_fetch");
        step(DECODE, 1'b1, "rtype_decode");
        step(EXEC, 1'b1, "rtype_exec");
        step(ALUWB, 1'b1, "rtype_aluwb");
        checks++;
        if (instret !== 32'd1) begin
            fails++;
            $display("FAIL rtype_instret: got %0d expected 1", instret);
        end
        step(FETCH, 1'b1, "rtype_next_fetch");
        $display("test_rtype done");
    endtask

    task automatic test_lw_wait();
        do_reset();
        op = 6'b100011;
        step(FETCH, 1'b1, "lw_fetch");
        step(DECODE, 1'b1, "lw_decode");
        op = 6'b101011;  // class must already be latched
        step(MEMADR, 1'b1, "lw_memadr");
        for (int i = 0; i < 3; i++) step(MEMRD, 1'b0, "lw_memrd_wait");
        step(MEMRD, 1'b1, "lw_memrd_done");
        step(MEMWB, 1'b1, "lw_memwb");
        checks++;
        if (instret !== 32'd1) begin
            fails++;
            $display("FAIL lw_instret: got %0d expected 1", instret);
        end
        step(FETCH, 1'b1, "lw_next_fetch");
        $display("test_lw_wait done");
    endtask

    task automatic test_back_to_back();
        do_reset();
        op = 6'b101011;
        step(FETCH, 1'b1, "sw_fetch");
        step(DECODE, 1'b0, "sw_decode");
        step(MEMADR, 1'b0, "sw_memadr");
        step(MEMWR, 1'b0, "sw_memwr_wait");
        checks++;
        if (instret !== 32'd0) begin
            fails++;
            $display("FAIL sw_wait_instret: got %0d expected 0", instret);
        end
        step(MEMWR, 1'b1, "sw_memwr");
        op = 6'b000100;
        step(FETCH, 1'b1, "beq_fetch");
        step(DECODE, 1'b1, "beq_decode");
        step(BEQ, 1'b0, "beq_exec");
        checks++;
        if (instret !== 32'd2) begin
            fails++;
            $display("FAIL swbeq_instret: got %0d expected 2", instret);
        end
        op = 6'b001000;
        step(FETCH, 1'b1, "addi_fetch");
        step(DECODE, 1'b1, "addi_decode");
        step(ADDIEX, 1'b1, "addi_ex");
        step(ADDIWB, 1'b1, "addi_wb");
        checks++;
        if (instret !== 32'd3) begin
            fails++;
            $display("FAIL addi_instret: got %0d expected 3", instret);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_ext();
        do_reset();
        op = 6'b100101;
        step(FETCH, 1'b1, "lhu_fetch");
        step(DECODE, 1'b1, "lhu_decode");
        checks++;
        if (x_ctrl !== exp_ctrl(TRAP, 1'b1)) begin
            fails++;
            $display("FAIL noext_lhu_trap: ctrl=%b expected %b", x_ctrl, exp_ctrl(TRAP, 1'b1));
        end
        step(MEMADR, 1'b1, "lhu_memadr");
        step(MEMRD, 1'b1, "lhu_memrd");
        step(MEMWBH, 1'b1, "lhu_memwb");
        op = 6'b011101;
        step(FETCH, 1'b1, "blt_fetch");
        step(DECODE, 1'b1, "blt_decode");
        step(BLTX, 1'b1, "blt_exec");
        checks++;
        if (instret !== 32'd2) begin
            fails++;
            $display("FAIL ext_instret: got %0d expected 2", instret);
        end
        do_reset();
        op = 6'b011101;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            @(negedge clk);
            checks++;
            if (x_illegal !== 1'b1 || x_ctrl !== exp_ctrl(TRAP, 1'b1) || x_instret !== 32'd0) begin
                fails++;
                $display("FAIL noext_blt_trap: ctrl=%b instret=%0d expected %b and 0",
                         x_ctrl, x_instret, exp_ctrl(TRAP, 1'b1));
            end
            @(posedge clk); #1;
        end
        $display("test_ext done");
    endtask

    task automatic test_trap();
        do_reset();
        op = 6'b000000;
        step(FETCH, 1'b1, "pre_trap_fetch");
        step(DECODE, 1'b1, "pre_trap_decode");
        step(EXEC, 1'b1, "pre_trap_exec");
        step(ALUWB, 1'b1, "pre_trap_aluwb");
        op = 6'b111111;
        step(FETCH, 1'b1, "trap_fetch");
        step(DECODE, 1'b1, "trap_decode");
        for (int i = 0; i < 5; i++) begin
            op = 6'b000010;
            step(TRAP, i[0], "trap_hold");
        end
        checks++;
        if (instret !== 32'd1) begin
            fails++;
            $display("FAIL trap_instret: got %0d expected 1", instret);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (ctrl !== 19'd0 || instret !== 32'd0) begin
            fails++;
            $display("FAIL trap_reset: ctrl=%b instret=%0d expected 0 and 0", ctrl, instret);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        step(FETCH, 1'b1, "trap_after_reset");
        $display("test_trap done");
    endtask

    task automatic test_reset_midaccess();
        do_reset();
        op = 6'b100011;
        step(FETCH, 1'b1, "mid_fetch");
        step(DECODE, 1'b1, "mid_decode");
        step(MEMADR, 1'b1, "mid_memadr");
        step(MEMRD, 1'b0, "mid_memrd_wait");
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (ctrl !== 19'd0) begin
            fails++;
            $display("FAIL mid_reset_outputs: ctrl=%b expected 0", ctrl);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        step(FETCH, 1'b0, "mid_fetch_after");
        step(FETCH, 1'b1, "mid_fetch_ready");
        $display("test_reset_midaccess done");
    endtask

    task automatic test_wrap();
        do_reset();
        op = 6'b000010;
        for (int i = 0; i < 16; i++) begin
            step(FETCH, 1'b1, "j_fetch");
            step(DECODE, 1'b1, "j_decode");
            step(JUMP, 1'b1, "j_jump");
            if (i == 14) begin
                checks++;
                if (c_instret !== 4'd15) begin
                    fails++;
                    $display("FAIL wrap_pre: got %0d expected 15", c_instret);
                end
            end
        end
        checks++;
        if (c_instret !== 4'd0 || instret !== 32'd16) begin
            fails++;
            $display("FAIL wrap: cnt4=%0d cnt32=%0d expected 0 and 16", c_instret, instret);
        end
        $display("test_wrap done");
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_back_to_back();
        test_ext();
        test_trap();
        test_reset_midaccess();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
